crash_controller: RTL and testbench
===================================

CRASH_CONTROLLER -- requirements
Module: crash_controller

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3, lives loaded at game start (1..7).
REQ-002 SHALL have parameter CRASH_FRAMES, default 60, frames spent in crash sequence (1..255).
REQ-003 SHALL have parameter BLINK_PERIOD, default 8, frames per player_visible toggle during crash (1..255).
REQ-004 SHALL have parameter GRACE_FRAMES, default 90, post-respawn frames during which collisions are ignored (0..255).
REQ-005 SHALL have port clk  input  1  system clock; all state changes on rising edge.
REQ-006 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-007 SHALL have port frame_tick  input  1  one-cycle pulse per video frame.
REQ-008 SHALL have port colision  input  1  level collision flag from colisionManager (player vs any of 6 enemies).
REQ-009 SHALL have port start  input  1  start/restart request, level, sampled every cycle.
REQ-010 SHALL have port freeze  output  1  high = enemy/road/player motion halted.
REQ-011 SHALL have port player_visible  output  1  player sprite enable.
REQ-012 SHALL have port lives  output  3  remaining lives.
REQ-013 SHALL have port game_over  output  1  high while in GAME_OVER.
REQ-014 SHALL have port crash_pulse  output  1  one-cycle pulse on crash detection.
REQ-015 SHALL have port respawn  output  1  one-cycle pulse when play resumes after crash; position modules recentre player on it.
REQ-016 SHALL have port state  output  2  current state: IDLE=0, PLAY=1, CRASH=2, GAME_OVER=3.

Function
REQ-017 SHALL implement FSM IDLE, PLAY, CRASH, GAME_OVER; all outputs registered.
REQ-018 In IDLE SHALL drive freeze=1, player_visible=1; start=1 -> PLAY next cycle, lives<=LIVES_INIT, grace counter<=0.
REQ-019 In PLAY SHALL drive freeze=0, player_visible=1.
REQ-020 In PLAY, on frame_tick with grace counter>0, SHALL decrement grace counter and ignore colision.
REQ-021 In PLAY, on frame_tick with grace counter=0 and colision=1, SHALL enter CRASH, pulse crash_pulse one cycle, decrement lives (saturate at 0), clear frame and blink counters, set player_visible=0.
REQ-022 colision SHALL be sampled only on frame_tick cycles; colision high between ticks has no effect.
REQ-023 In CRASH SHALL drive freeze=1; each frame_tick increments frame counter (8-bit) and blink counter; blink counter reaching BLINK_PERIOD toggles player_visible and clears to 0.
REQ-024 In CRASH, on the frame_tick where frame counter equals CRASH_FRAMES-1: lives=0 -> GAME_OVER; else -> PLAY, respawn pulse one cycle, grace counter<=GRACE_FRAMES, player_visible=1.
REQ-025 In GAME_OVER SHALL drive game_over=1, freeze=1, player_visible=1; start=1 -> PLAY with lives<=LIVES_INIT, grace counter<=0, game_over=0.
REQ-026 start SHALL be ignored in PLAY and CRASH.
REQ-027 start and frame_tick in the same IDLE/GAME_OVER cycle: start wins; the tick causes no counter change.
REQ-028 crash_pulse and respawn SHALL never be high in the same cycle; each high at most one cycle per event.
REQ-029 GRACE_FRAMES=0 SHALL allow collision detection on the first frame_tick after respawn.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force, regardless of state (including mid-CRASH): state=IDLE, lives=LIVES_INIT, freeze=1, player_visible=1, game_over=0, crash_pulse=0, respawn=0, all counters 0.
REQ-031 Reset SHALL override start, frame_tick and colision in the same cycle.

Verification (LIVES_INIT=3, CRASH_FRAMES=4, BLINK_PERIOD=2, GRACE_FRAMES=3)
REQ-032 Reset, then start 1 cycle -> state=1, lives=3, freeze=0, game_over=0.
REQ-033 PLAY, colision=1 on a frame_tick -> next cycle state=2, crash_pulse=1 (one cycle), lives=2, player_visible=0; after 2 ticks visible=1; on 4th tick state=1, respawn=1 one cycle.
REQ-034 After respawn, colision held high -> no crash for 3 frame_ticks; 4th tick -> CRASH, lives=1.
REQ-035 Three crashes from start -> lives=0, state=3, game_over=1, freeze=1; start -> state=1, lives=3.
REQ-036 colision pulsed high only between frame_ticks -> state stays 1, lives unchanged.
REQ-037 rst_n=0 mid-CRASH (frame counter=2) -> next cycle state=0, lives=3, freeze=1, player_visible=1, no respawn pulse.

Source files
------------

// File: rtl/crash_controller.sv
// crash_controller: player crash / respawn / lives sequencer.
// Drives motion freeze, sprite blink and game-over state for the road game.
module crash_controller #(
  parameter int LIVES_INIT   = 3,
  parameter int CRASH_FRAMES = 60,
  parameter int BLINK_PERIOD = 8,
  parameter int GRACE_FRAMES = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       colision,
  input  logic       start,
  output logic       freeze,
  output logic       player_visible,
  output logic [2:0] lives,
  output logic       game_over,
  output logic       crash_pulse,
  output logic       respawn,
  output logic [1:0] state
);

  localparam logic [2:0] LIVES_LD   = 3'(LIVES_INIT);
  localparam logic [7:0] LAST_FRAME = 8'(CRASH_FRAMES - 1);
  localparam logic [7:0] BLINK_LEN  = 8'(BLINK_PERIOD);
  localparam logic [7:0] GRACE_LD   = 8'(GRACE_FRAMES);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    CRASH     = 2'd2,
    GAME_OVER = 2'd3
  } state_e;

  state_e     cur, nxt;
  logic [7:0] grace, grace_n;
  logic [7:0] frame, frame_n;
  logic [7:0] blink, blink_n;
  logic [7:0] blink_inc;
  logic [2:0] lives_n;
  logic       vis_n;
  logic       freeze_n;
  logic       over_n;
  logic       crash_n;
  logic       respawn_n;

  assign state     = cur;
  assign blink_inc = blink + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur            <= IDLE;
      lives          <= LIVES_LD;
      grace          <= 8'd0;
      frame          <= 8'd0;
      blink          <= 8'd0;
      freeze         <= 1'b1;
      player_visible <= 1'b1;
      game_over      <= 1'b0;
      crash_pulse    <= 1'b0;
      respawn        <= 1'b0;
    end else begin
      cur            <= nxt;
      lives          <= lives_n;
      grace          <= grace_n;
      frame          <= frame_n;
      blink          <= blink_n;
      freeze         <= freeze_n;
      player_visible <= vis_n;
      game_over      <= over_n;
      crash_pulse    <= crash_n;
      respawn        <= respawn_n;
    end
  end

  always_comb begin
    nxt       = cur;
    lives_n   = lives;
    grace_n   = grace;
    frame_n   = frame;
    blink_n   = blink;
    vis_n     = player_visible;
    crash_n   = 1'b0;
    respawn_n = 1'b0;

    unique case (cur)
      IDLE, GAME_OVER: begin
        // start has priority; a concurrent tick changes nothing
        if (start) begin
          nxt     = PLAY;
          lives_n = LIVES_LD;
          grace_n = 8'd0;
          vis_n   = 1'b1;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          if (grace != 8'd0) begin
            grace_n = grace - 8'd1;
          end else if (colision) begin
            nxt     = CRASH;
            crash_n = 1'b1;
            lives_n = (lives == 3'd0) ? 3'd0 : lives - 3'd1;
            frame_n = 8'd0;
            blink_n = 8'd0;
            vis_n   = 1'b0;
          end
        end
      end
      CRASH: begin
        if (frame_tick) begin
          if (frame == LAST_FRAME) begin
            vis_n = 1'b1;
            if (lives == 3'd0) begin
              nxt = GAME_OVER;
            end else begin
              nxt       = PLAY;
              respawn_n = 1'b1;
              grace_n   = GRACE_LD;
            end
          end else begin
            frame_n = frame + 8'd1;
            if (blink_inc == BLINK_LEN) begin
              blink_n = 8'd0;
              vis_n   = ~player_visible;
            end else begin
              blink_n = blink_inc;
            end
          end
        end
      end
      default: nxt = IDLE;
    endcase

    freeze_n = (nxt != PLAY);
    over_n   = (nxt == GAME_OVER);
  end

endmodule

// File: tb/tb_crash_controller.sv
// tb_crash_controller: directed checks of crash_controller
// with LIVES_INIT=3, CRASH_FRAMES=4, BLINK_PERIOD=2, GRACE_FRAMES=3.
module tb_crash_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       colision;
  logic       start;
  logic       freeze;
  logic       player_visible;
  logic [2:0] lives;
  logic       game_over;
  logic       crash_pulse;
  logic       respawn;
  logic [1:0] state;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  crash_controller #(
    .LIVES_INIT  (3),
    .CRASH_FRAMES(4),
    .BLINK_PERIOD(2),
    .GRACE_FRAMES(3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_tick    (frame_tick),
    .colision      (colision),
    .start         (start),
    .freeze        (freeze),
    .player_visible(player_visible),
    .lives         (lives),
    .game_over     (game_over),
    .crash_pulse   (crash_pulse),
    .respawn       (respawn),
    .state         (state)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic col);
    frame_tick = 1'b1;
    colision   = col;
    cyc();
    frame_tick = 1'b0;
    colision   = 1'b0;
  endtask

  task automatic crash_seq_to_end();
    for (int i = 0; i < 4; i++) tick(1'b0);
  endtask

  initial begin
    // reset overrides start/tick/colision
    rst_n = 1'b0; start = 1'b1; frame_tick = 1'b1; colision = 1'b1;
    cyc(); cyc();
    chk("rst_state", 8'(state), 8'd0);
    chk("rst_lives", 8'(lives), 8'd3);
    chk("rst_freeze", 8'(freeze), 8'd1);
    chk("rst_vis", 8'(player_visible), 8'd1);
    chk("rst_over", 8'(game_over), 8'd0);
    chk("rst_crash", 8'(crash_pulse), 8'd0);
    chk("rst_resp", 8'(respawn), 8'd0);

    rst_n = 1'b1; start = 1'b0; frame_tick = 1'b0; colision = 1'b0;
    tick(1'b1);
    chk("idle_tick_state", 8'(state), 8'd0);

    start = 1'b1; cyc(); start = 1'b0;
    chk("start_state", 8'(state), 8'd1);
    chk("start_lives", 8'(lives), 8'd3);
    chk("start_freeze", 8'(freeze), 8'd0);
    chk("start_over", 8'(game_over), 8'd0);

    // colision between ticks only
    colision = 1'b1; cyc(); cyc(); cyc(); colision = 1'b0;
    tick(1'b0);
    chk("between_state", 8'(state), 8'd1);
    chk("between_lives", 8'(lives), 8'd3);

    // first crash
    tick(1'b1);
    chk("c1_state", 8'(state), 8'd2);
    chk("c1_pulse", 8'(crash_pulse), 8'd1);
    chk("c1_lives", 8'(lives), 8'd2);
    chk("c1_vis", 8'(player_visible), 8'd0);
    chk("c1_freeze", 8'(freeze), 8'd1);
    start = 1'b1; cyc(); start = 1'b0;
    chk("c1_pulse_off", 8'(crash_pulse), 8'd0);
    chk("c1_start_ign", 8'(state), 8'd2);
    tick(1'b0);
    chk("c1_t1_vis", 8'(player_visible), 8'd0);
    tick(1'b0);
    chk("c1_t2_vis", 8'(player_visible), 8'd1);
    tick(1'b0);
    chk("c1_t3_state", 8'(state), 8'd2);
    tick(1'b0);
    chk("c1_t4_state", 8'(state), 8'd1);
    chk("c1_respawn", 8'(respawn), 8'd1);
    chk("c1_resp_nocr", 8'(crash_pulse), 8'd0);
    chk("c1_resp_vis", 8'(player_visible), 8'd1);
    chk("c1_resp_frz", 8'(freeze), 8'd0);
    cyc();
    chk("c1_resp_off", 8'(respawn), 8'd0);

    // grace: three ignored ticks, fourth crashes
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      chk("grace_state", 8'(state), 8'd1);
    end
    start = 1'b0;
    chk("grace_lives", 8'(lives), 8'd2);
    tick(1'b1);
    chk("c2_state", 8'(state), 8'd2);
    chk("c2_lives", 8'(lives), 8'd1);
    chk("c2_pulse", 8'(crash_pulse), 8'd1);
    crash_seq_to_end();
    chk("c2_resp", 8'(respawn), 8'd1);

    // third crash -> game over
    for (int i = 0; i < 3; i++) tick(1'b0);
    tick(1'b1);
    chk("c3_lives", 8'(lives), 8'd0);
    chk("c3_state", 8'(state), 8'd2);
    crash_seq_to_end();
    chk("go_state", 8'(state), 8'd3);
    chk("go_over", 8'(game_over), 8'd1);
    chk("go_freeze", 8'(freeze), 8'd1);
    chk("go_vis", 8'(player_visible), 8'd1);
    chk("go_no_resp", 8'(respawn), 8'd0);
    tick(1'b1);
    chk("go_tick_state", 8'(state), 8'd3);

    // start and tick together in GAME_OVER: start wins
    start = 1'b1; frame_tick = 1'b1; cyc();
    start = 1'b0; frame_tick = 1'b0;
    chk("rs_state", 8'(state), 8'd1);
    chk("rs_lives", 8'(lives), 8'd3);
    chk("rs_over", 8'(game_over), 8'd0);
    chk("rs_freeze", 8'(freeze), 8'd0);

    // grace cleared on restart: immediate crash possible
    tick(1'b1);
    chk("c4_state", 8'(state), 8'd2);
    chk("c4_lives", 8'(lives), 8'd2);
    tick(1'b0);
    tick(1'b0);
    chk("c4_mid_state", 8'(state), 8'd2);

    // reset mid-crash with frame counter at 2
    rst_n = 1'b0; frame_tick = 1'b1; colision = 1'b1; start = 1'b1;
    cyc();
    rst_n = 1'b1; frame_tick = 1'b0; colision = 1'b0; start = 1'b0;
    chk("mr_state", 8'(state), 8'd0);
    chk("mr_lives", 8'(lives), 8'd3);
    chk("mr_freeze", 8'(freeze), 8'd1);
    chk("mr_vis", 8'(player_visible), 8'd1);
    chk("mr_resp", 8'(respawn), 8'd0);
    chk("mr_over", 8'(game_over), 8'd0);
    tick(1'b0); tick(1'b0);
    chk("mr_idle_state", 8'(state), 8'd0);
    chk("mr_idle_resp", 8'(respawn), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
